// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round helpers for the cipher and key schedule.
// State byte (c, r) is block byte 4c+r, with byte 0 in the most significant position.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef logic [7:0] aes_byte_t;
    typedef aes_byte_t [0:3] aes_col_t;
    typedef aes_col_t [0:3] aes_state_t;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_ROUND = 2'd1,
        FSM_DONE  = 2'd2
    } aes_fsm_e;

    localparam logic [0:9][7:0] AES_RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic aes_byte_t aes_xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t aes_shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[c][r] = s[(c + r) % 4][r];
            end
        end
        return o;
    endfunction

    // 2*a ^ 3*b is folded into xtime(a ^ b) ^ b
    function automatic aes_col_t aes_mix_col(input aes_col_t a);
        aes_col_t o;
        for (int r = 0; r < 4; r++) begin
            o[r] = aes_xtime(a[r] ^ a[(r + 1) % 4])
                 ^ a[(r + 1) % 4]
                 ^ a[(r + 2) % 4]
                 ^ a[(r + 3) % 4];
        end
        return o;
    endfunction

    function automatic aes_state_t aes_mix_columns(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            o[c] = aes_mix_col(s[c]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
// Shared by the cipher rounds and the key-expansion stage.
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);

    always_comb begin
        o_y = 8'h00;
        case (i_a)
            8'h00: o_y = 8'h63; 8'h01: o_y = 8'h7c; 8'h02: o_y = 8'h77; 8'h03: o_y = 8'h7b;
            8'h04: o_y = 8'hf2; 8'h05: o_y = 8'h6b; 8'h06: o_y = 8'h6f; 8'h07: o_y = 8'hc5;
            8'h08: o_y = 8'h30; 8'h09: o_y = 8'h01; 8'h0a: o_y = 8'h67; 8'h0b: o_y = 8'h2b;
            8'h0c: o_y = 8'hfe; 8'h0d: o_y = 8'hd7; 8'h0e: o_y = 8'hab; 8'h0f: o_y = 8'h76;
            8'h10: o_y = 8'hca; 8'h11: o_y = 8'h82; 8'h12: o_y = 8'hc9; 8'h13: o_y = 8'h7d;
            8'h14: o_y = 8'hfa; 8'h15: o_y = 8'h59; 8'h16: o_y = 8'h47; 8'h17: o_y = 8'hf0;
            8'h18: o_y = 8'had; 8'h19: o_y = 8'hd4; 8'h1a: o_y = 8'ha2; 8'h1b: o_y = 8'haf;
            8'h1c: o_y = 8'h9c; 8'h1d: o_y = 8'ha4; 8'h1e: o_y = 8'h72; 8'h1f: o_y = 8'hc0;
            8'h20: o_y = 8'hb7; 8'h21: o_y = 8'hfd; 8'h22: o_y = 8'h93; 8'h23: o_y = 8'h26;
            8'h24: o_y = 8'h36; 8'h25: o_y = 8'h3f; 8'h26: o_y = 8'hf7; 8'h27: o_y = 8'hcc;
            8'h28: o_y = 8'h34; 8'h29: o_y = 8'ha5; 8'h2a: o_y = 8'he5; 8'h2b: o_y = 8'hf1;
            8'h2c: o_y = 8'h71; 8'h2d: o_y = 8'hd8; 8'h2e: o_y = 8'h31; 8'h2f: o_y = 8'h15;
            8'h30: o_y = 8'h04; 8'h31: o_y = 8'hc7; 8'h32: o_y = 8'h23; 8'h33: o_y = 8'hc3;
            8'h34: o_y = 8'h18; 8'h35: o_y = 8'h96; 8'h36: o_y = 8'h05; 8'h37: o_y = 8'h9a;
            8'h38: o_y = 8'h07; 8'h39: o_y = 8'h12; 8'h3a: o_y = 8'h80; 8'h3b: o_y = 8'he2;
            8'h3c: o_y = 8'heb; 8'h3d: o_y = 8'h27; 8'h3e: o_y = 8'hb2; 8'h3f: o_y = 8'h75;
            8'h40: o_y = 8'h09; 8'h41: o_y = 8'h83; 8'h42: o_y = 8'h2c; 8'h43: o_y = 8'h1a;
            8'h44: o_y = 8'h1b; 8'h45: o_y = 8'h6e; 8'h46: o_y = 8'h5a; 8'h47: o_y = 8'ha0;
            8'h48: o_y = 8'h52; 8'h49: o_y = 8'h3b; 8'h4a: o_y = 8'hd6; 8'h4b: o_y = 8'hb3;
            8'h4c: o_y = 8'h29; 8'h4d: o_y = 8'he3; 8'h4e: o_y = 8'h2f; 8'h4f: o_y = 8'h84;
            8'h50: o_y = 8'h53; 8'h51: o_y = 8'hd1; 8'h52: o_y = 8'h00; 8'h53: o_y = 8'hed;
            8'h54: o_y = 8'h20; 8'h55: o_y = 8'hfc; 8'h56: o_y = 8'hb1; 8'h57: o_y = 8'h5b;
            8'h58: o_y = 8'h6a; 8'h59: o_y = 8'hcb; 8'h5a: o_y = 8'hbe; 8'h5b: o_y = 8'h39;
            8'h5c: o_y = 8'h4a; 8'h5d: o_y = 8'h4c; 8'h5e: o_y = 8'h58; 8'h5f: o_y = 8'hcf;
            8'h60: o_y = 8'hd0; 8'h61: o_y = 8'hef; 8'h62: o_y = 8'haa; 8'h63: o_y = 8'hfb;
            8'h64: o_y = 8'h43; 8'h65: o_y = 8'h4d; 8'h66: o_y = 8'h33; 8'h67: o_y = 8'h85;
            8'h68: o_y = 8'h45; 8'h69: o_y = 8'hf9; 8'h6a: o_y = 8'h02; 8'h6b: o_y = 8'h7f;
            8'h6c: o_y = 8'h50; 8'h6d: o_y = 8'h3c; 8'h6e: o_y = 8'h9f; 8'h6f: o_y = 8'ha8;
            8'h70: o_y = 8'h51; 8'h71: o_y = 8'ha3; 8'h72: o_y = 8'h40; 8'h73: o_y = 8'h8f;
            8'h74: o_y = 8'h92; 8'h75: o_y = 8'h9d; 8'h76: o_y = 8'h38; 8'h77: o_y = 8'hf5;
            8'h78: o_y = 8'hbc; 8'h79: o_y = 8'hb6; 8'h7a: o_y = 8'hda; 8'h7b: o_y = 8'h21;
            8'h7c: o_y = 8'h10; 8'h7d: o_y = 8'hff; 8'h7e: o_y = 8'hf3; 8'h7f: o_y = 8'hd2;
            8'h80: o_y = 8'hcd; 8'h81: o_y = 8'h0c; 8'h82: o_y = 8'h13; 8'h83: o_y = 8'hec;
            8'h84: o_y = 8'h5f; 8'h85: o_y = 8'h97; 8'h86: o_y = 8'h44; 8'h87: o_y = 8'h17;
            8'h88: o_y = 8'hc4; 8'h89: o_y = 8'ha7; 8'h8a: o_y = 8'h7e; 8'h8b: o_y = 8'h3d;
            8'h8c: o_y = 8'h64; 8'h8d: o_y = 8'h5d; 8'h8e: o_y = 8'h19; 8'h8f: o_y = 8'h73;
            8'h90: o_y = 8'h60; 8'h91: o_y = 8'h81; 8'h92: o_y = 8'h4f; 8'h93: o_y = 8'hdc;
            8'h94: o_y = 8'h22; 8'h95: o_y = 8'h2a; 8'h96: o_y = 8'h90; 8'h97: o_y = 8'h88;
            8'h98: o_y = 8'h46; 8'h99: o_y = 8'hee; 8'h9a: o_y = 8'hb8; 8'h9b: o_y = 8'h14;
            8'h9c: o_y = 8'hde; 8'h9d: o_y = 8'h5e; 8'h9e: o_y = 8'h0b; 8'h9f: o_y = 8'hdb;
            8'ha0: o_y = 8'he0; 8'ha1: o_y = 8'h32; 8'ha2: o_y = 8'h3a; 8'ha3: o_y = 8'h0a;
            8'ha4: o_y = 8'h49; 8'ha5: o_y = 8'h06; 8'ha6: o_y = 8'h24; 8'ha7: o_y = 8'h5c;
            8'ha8: o_y = 8'hc2; 8'ha9: o_y = 8'hd3; 8'haa: o_y = 8'hac; 8'hab: o_y = 8'h62;
            8'hac: o_y = 8'h91; 8'had: o_y = 8'h95; 8'hae: o_y = 8'he4; 8'haf: o_y = 8'h79;
            8'hb0: o_y = 8'he7; 8'hb1: o_y = 8'hc8; 8'hb2: o_y = 8'h37; 8'hb3: o_y = 8'h6d;
            8'hb4: o_y = 8'h8d; 8'hb5: o_y = 8'hd5; 8'hb6: o_y = 8'h4e; 8'hb7: o_y = 8'ha9;
            8'hb8: o_y = 8'h6c; 8'hb9: o_y = 8'h56; 8'hba: o_y = 8'hf4; 8'hbb: o_y = 8'hea;
            8'hbc: o_y = 8'h65; 8'hbd: o_y = 8'h7a; 8'hbe: o_y = 8'hae; 8'hbf: o_y = 8'h08;
            8'hc0: o_y = 8'hba; 8'hc1: o_y = 8'h78; 8'hc2: o_y = 8'h25; 8'hc3: o_y = 8'h2e;
            8'hc4: o_y = 8'h1c; 8'hc5: o_y = 8'ha6; 8'hc6: o_y = 8'hb4; 8'hc7: o_y = 8'hc6;
            8'hc8: o_y = 8'he8; 8'hc9: o_y = 8'hdd; 8'hca: o_y = 8'h74; 8'hcb: o_y = 8'h1f;
            8'hcc: o_y = 8'h4b; 8'hcd: o_y = 8'hbd; 8'hce: o_y = 8'h8b; 8'hcf: o_y = 8'h8a;
            8'hd0: o_y = 8'h70; 8'hd1: o_y = 8'h3e; 8'hd2: o_y = 8'hb5; 8'hd3: o_y = 8'h66;
            8'hd4: o_y = 8'h48; 8'hd5: o_y = 8'h03; 8'hd6: o_y = 8'hf6; 8'hd7: o_y = 8'h0e;
            8'hd8: o_y = 8'h61; 8'hd9: o_y = 8'h35; 8'hda: o_y = 8'h57; 8'hdb: o_y = 8'hb9;
            8'hdc: o_y = 8'h86; 8'hdd: o_y = 8'hc1; 8'hde: o_y = 8'h1d; 8'hdf: o_y = 8'h9e;
            8'he0: o_y = 8'he1; 8'he1: o_y = 8'hf8; 8'he2: o_y = 8'h98; 8'he3: o_y = 8'h11;
            8'he4: o_y = 8'h69; 8'he5: o_y = 8'hd9; 8'he6: o_y = 8'h8e; 8'he7: o_y = 8'h94;
            8'he8: o_y = 8'h9b; 8'he9: o_y = 8'h1e; 8'hea: o_y = 8'h87; 8'heb: o_y = 8'he9;
            8'hec: o_y = 8'hce; 8'hed: o_y = 8'h55; 8'hee: o_y = 8'h28; 8'hef: o_y = 8'hdf;
            8'hf0: o_y = 8'h8c; 8'hf1: o_y = 8'ha1; 8'hf2: o_y = 8'h89; 8'hf3: o_y = 8'h0d;
            8'hf4: o_y = 8'hbf; 8'hf5: o_y = 8'he6; 8'hf6: o_y = 8'h42; 8'hf7: o_y = 8'h68;
            8'hf8: o_y = 8'h41; 8'hf9: o_y = 8'h99; 8'hfa: o_y = 8'h2d; 8'hfb: o_y = 8'h0f;
            8'hfc: o_y = 8'hb0; 8'hfd: o_y = 8'h54; 8'hfe: o_y = 8'hbb; 8'hff: o_y = 8'h16;
            default: o_y = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption: one round per clock, round keys fetched by index.
// Valid/ready on plaintext in and ciphertext out; one block in flight at a time.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic                 key_valid,
    output logic [3:0]           rk_idx,
    input  logic [AES_BLK_W-1:0] rk,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_encrypt_iter supports only NR = 10");
        end
    endgenerate

    localparam logic [3:0] LAST = 4'(NR);

    aes_fsm_e             r_fsm;
    logic [3:0]           r_round;
    aes_state_t           r_state;
    logic                 r_out_valid;
    logic [AES_BLK_W-1:0] r_out_data;

    aes_byte_t  w_sb [0:15];
    aes_state_t w_sub;
    aes_state_t w_shift;
    aes_state_t w_mix;
    aes_state_t w_rk;
    aes_state_t w_next;
    logic       w_last;
    logic       w_accept;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .i_a (r_state[i / 4][i % 4]),
            .o_y (w_sb[i])
        );
    end

    always_comb begin
        w_sub = '0;
        for (int i = 0; i < 16; i++) begin
            w_sub[i / 4][i % 4] = w_sb[i];
        end
    end

    assign w_rk    = rk;
    assign w_shift = aes_shift_rows(w_sub);
    assign w_mix   = aes_mix_columns(w_shift);
    assign w_last  = (r_round == LAST);
    // The final round skips MixColumns
    assign w_next  = (w_last ? w_shift : w_mix) ^ w_rk;

    assign in_ready  = rst_n & key_valid & (r_fsm == FSM_IDLE);
    assign w_accept  = in_valid & in_ready;
    assign rk_idx    = (r_fsm == FSM_ROUND) ? r_round : 4'd0;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= FSM_IDLE;
            r_round     <= 4'd0;
            r_state     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_fsm)
                FSM_IDLE: begin
                    if (w_accept) begin
                        r_state <= in_data ^ rk;
                        r_round <= 4'd1;
                        r_fsm   <= FSM_ROUND;
                    end
                end
                FSM_ROUND: begin
                    r_state <= w_next;
                    r_round <= r_round + 4'd1;
                    if (w_last) begin
                        r_round     <= 4'd0;
                        r_out_data  <= w_next;
                        r_out_valid <= 1'b1;
                        r_fsm       <= FSM_DONE;
                    end
                end
                FSM_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= FSM_IDLE;
                    end
                end
                default: r_fsm <= FSM_IDLE;
            endcase
        end
    end

endmodule
